badhash_result_fifo: RTL
========================

# badhash_result_fifo

Downstream collector for the hash stage: captures each single-cycle result pulse from the hash block and buffers the results in a small show-ahead FIFO, so a slower consumer can drain them at its own pace. Sits directly on the hash stage's output pair (32-bit data plus 32-bit ready word, bit 0 significant). Overflow is recorded in a sticky flag rather than back-pressuring, because the hash stage has no stall input.

## Interface
- DEPTH, 4, number of result entries; power of two, 2..16
- WIDTH, 32, result word width; must match hash stage data width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- io_hash_data  in  WIDTH  result word from hash stage
- io_hash_ready  in  32  result strobe word from hash stage; only bit 0 used, bits 31:1 ignored
- io_pop  in  1  consumer removes head entry this cycle
- io_clear_ovf  in  1  clears sticky overflow flag
- io_out_data  out  WIDTH  head entry; 0 when empty
- io_out_valid  out  1  FIFO not empty
- io_count  out  $clog2(DEPTH+1)  entries held
- io_full  out  1  count == DEPTH
- io_overflow  out  1  sticky: a result was dropped
- io_checksum  out  WIDTH  running XOR of accepted results (only with RESULT_CHECKSUM_EN)
- io_total  out  16  accepted-result counter (only with RESULT_CHECKSUM_EN)

## Operation
- push = io_hash_ready[0]; pop_ok = io_pop & io_out_valid.
- Storage: DEPTH x WIDTH register array, write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH; separate count register.
- Push when not full: mem[wp] <= io_hash_data, wp++, count++.
- Push when full and io_pop high: push and pop both happen; count unchanged.
- Push when full and io_pop low: data dropped, io_overflow <= 1; pointers and count unchanged.
- Pop when empty: ignored; no pointer change, no error.
- Simultaneous push and pop with count 1..DEPTH-1: count unchanged, both pointers advance.
- Push into empty FIFO with io_pop high: pop ignored (empty this cycle), entry written.
- io_clear_ovf clears io_overflow; if a drop occurs the same cycle, the set wins (flag stays 1).
- io_out_data = mem[rp] when count != 0, else 0 (show-ahead, no read latency).
- No state machine beyond pointers/count; all state updates on the rising edge of clk.

## Timing
- Reset (sync, priority over all other inputs): wp = rp = 0, count = 0, io_overflow = 0, io_checksum = 0, io_total = 0; hence io_out_valid = 0, io_full = 0, io_out_data = 0, io_count = 0. Memory contents are not reset.
- Reset mid-operation: all held entries discarded. A push in the reset cycle is lost and is not counted as overflow.
- Push latency: a pulse sampled at edge N makes the data visible at io_out_data/io_out_valid after edge N (one cycle).
- Pop: the next entry (or 0/invalid) is presented after the edge that samples io_pop.
- Throughput: one push and one pop per cycle sustained; back-to-back pulses from the hash stage are all accepted if not full.
- Flags io_full, io_out_valid, io_count are derived from registered count only; no combinational path from io_pop to io_out_valid.

## Configuration
- RESULT_CHECKSUM_EN defined: io_checksum and io_total ports present. Each accepted push does io_checksum ^= io_hash_data and io_total += 1; io_total wraps from 0xFFFF to 0. Dropped results are not included.
- Not defined: both ports and their registers are absent; FIFO behaviour is identical.

## Test plan
- Reset, then idle -> io_out_valid 0, io_count 0, io_out_data 0x00000000, io_overflow 0.
- Push 0x11111111 then 0x22222222 on consecutive cycles -> io_count 2, io_out_data 0x11111111; pop -> io_out_data 0x22222222; pop -> empty, data 0.
- Push 5 results with DEPTH 4 and no pops -> io_full 1, io_overflow 1, the first 4 results drain in order, and the 5th is never output.
- While full, push 0xAAAA5555 with io_pop high -> count stays 4, the head advances, and 0xAAAA5555 is delivered last; io_overflow stays 0. Pop when empty -> no change.
- Push 0xDEADBEEF then 0x0000FFFF with RESULT_CHECKSUM_EN -> io_checksum 0xDEAD4110, io_total 2. A dropped push leaves both unchanged.
- io_hash_ready = 0xFFFFFFFE (bit 0 clear) -> no push. Assert reset with 3 entries held -> empty next cycle; io_overflow set and io_clear_ovf in the same cycle as a drop -> stays 1.

Source files
------------

// File: rtl/badhash_result_fifo.sv
// badhash_result_fifo: show-ahead result FIFO behind the hash stage.
// Each single-cycle strobe (io_hash_ready[0]) enqueues io_hash_data.
// There is no back-pressure. A result that arrives while the FIFO is full
// and not being popped is dropped, and the drop is recorded in a sticky
// overflow flag.
// Optional build macro: RESULT_CHECKSUM_EN adds the io_checksum and
// io_total ports, which track accepted results.
module badhash_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           io_hash_data,
  input  logic [31:0]                io_hash_ready,
  input  logic                       io_pop,
  input  logic                       io_clear_ovf,
  output logic [WIDTH-1:0]           io_out_data,
  output logic                       io_out_valid,
  output logic [$clog2(DEPTH+1)-1:0] io_count,
  output logic                       io_full,
  output logic                       io_overflow
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]           io_checksum,
  output logic [15:0]                io_total
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    count;
  logic             overflow;

  logic push;
  logic pop_ok;
  logic full;
  logic accept;
  logic drop;
  logic unused_ready_hi;

  // Only bit 0 of the strobe word carries meaning.
  assign unused_ready_hi = ^io_hash_ready[31:1];

  // Decode push/pop qualification from registered occupancy.
  always_comb begin
    push   = io_hash_ready[0];
    full   = (count == CW'(DEPTH));
    pop_ok = io_pop & (count != '0);
    // When full, a push is accepted only if a pop frees the head slot this cycle.
    accept = push & (~full | pop_ok);
    drop   = push & full & ~io_pop;
  end

  // Pointer, count, and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wp <= wp + 1'b1;
      end
      if (pop_ok) begin
        rp <= rp + 1'b1;
      end
      if (accept && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !accept) begin
        count <= count - 1'b1;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (io_clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage array; contents are not reset, and a write in the reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem[wp] <= io_hash_data;
    end
  end

`ifdef RESULT_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;
  logic [15:0]      total;

  // Running XOR and count of accepted results; dropped results are excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
      total    <= '0;
    end else if (accept) begin
      checksum <= checksum ^ io_hash_data;
      total    <= total + 16'd1;
    end
  end

  // Export the checksum registers.
  always_comb begin
    io_checksum = checksum;
    io_total    = total;
  end
`endif

  // Show-ahead head and status flags, all derived from registered state.
  always_comb begin
    io_out_valid = (count != '0);
    io_out_data  = (count != '0) ? mem[rp] : '0;
    io_count     = count;
    io_full      = full;
    io_overflow  = overflow;
  end

endmodule
